// File: rtl/dcpu_pkg.sv
// Shared constants for the dcpu register file with pointer pairs.
// Latency: n/a (constants only).
// Backpressure: n/a.
package dcpu_pkg;

  // Pointer-pair operation encoding
  localparam logic [1:0] PTR_NOP = 2'b00;
  localparam logic [1:0] PTR_INC = 2'b01;
  localparam logic [1:0] PTR_DEC = 2'b10;
  localparam logic [1:0] PTR_RSV = 2'b11;

  // Default geometry
  localparam int DCPU_DATA_W = 8;
  localparam int DCPU_NREGS  = 16;

endpackage

// File: rtl/dcpu_regfile_ptr_if.sv
// Bus bundle between the dcpu datapath and the pointer-capable register file.
// Latency: n/a (wires only); reads combinational, writes/pointer ops take effect next edge.
// Backpressure: none; every load and pointer op is accepted in the cycle it is presented.
interface dcpu_regfile_ptr_if
  import dcpu_pkg::*;
#(
  parameter int DATA_W = DCPU_DATA_W,
  parameter int NREGS  = DCPU_NREGS
);
  localparam int SEL_W  = $clog2(NREGS);
  localparam int PSEL_W = $clog2(NREGS / 2);
  localparam int ADDR_W = 2 * DATA_W;

  logic [DATA_W-1:0] i_dat;
  logic              i_load;
  logic [SEL_W-1:0]  i_load_reg_sel;
  logic [SEL_W-1:0]  i_alu_l_sel;
  logic [SEL_W-1:0]  i_alu_r_sel;
  logic [DATA_W-1:0] o_alu_l;
  logic [DATA_W-1:0] o_alu_r;
  logic [PSEL_W-1:0] i_addr_sel;
  logic [ADDR_W-1:0] o_addr;
  logic [1:0]        i_ptr_op;
  logic [PSEL_W-1:0] i_ptr_sel;
  logic              o_ptr_wrap;
  logic              o_ptr_conflict;

  // Datapath side: drives selects, data and pointer ops
  modport master (
    output i_dat, i_load, i_load_reg_sel, i_alu_l_sel, i_alu_r_sel,
    output i_addr_sel, i_ptr_op, i_ptr_sel,
    input  o_alu_l, o_alu_r, o_addr, o_ptr_wrap, o_ptr_conflict
  );

  // Register file side
  modport slave (
    input  i_dat, i_load, i_load_reg_sel, i_alu_l_sel, i_alu_r_sel,
    input  i_addr_sel, i_ptr_op, i_ptr_sel,
    output o_alu_l, o_alu_r, o_addr, o_ptr_wrap, o_ptr_conflict
  );
endinterface

// File: rtl/dcpu_ptr_incdec.sv
// Combinational +1/-1 unit for a full pointer, flags modular wrap-around.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module dcpu_ptr_incdec #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] i_val,
  input  logic              i_dec,
  output logic [ADDR_W-1:0] o_res,
  output logic              o_wrap
);

  // Step the pointer; wrap is all-ones on increment or zero on decrement
  always_comb begin
    o_res  = i_val + ADDR_W'(1);
    o_wrap = &i_val;
    if (i_dec) begin
      o_res  = i_val - ADDR_W'(1);
      o_wrap = ~|i_val;
    end
  end

endmodule

// File: rtl/dcpu_regfile_ptr.sv
// Register file with even/odd pairs usable as post-inc/post-dec pointers; optional DCPU_RF_BYPASS_EN write-through.
// Latency: reads 0 cycles; loads and pointer ops visible 1 cycle later; flags pulse the cycle after the op.
// Backpressure: none; a load hitting the targeted pair drops the pointer op and raises o_ptr_conflict.
module dcpu_regfile_ptr
  import dcpu_pkg::*;
#(
  parameter int DATA_W = DCPU_DATA_W,
  parameter int NREGS  = DCPU_NREGS
) (
  input logic              i_clk,
  input logic              i_reset_n,
  dcpu_regfile_ptr_if.slave bus
);

  localparam int SEL_W  = $clog2(NREGS);
  localparam int NPAIRS = NREGS / 2;
  localparam int PSEL_W = $clog2(NPAIRS);
  localparam int ADDR_W = 2 * DATA_W;

  logic [DATA_W-1:0] regs [NREGS];

  logic [SEL_W-1:0]  ptr_lo_idx;
  logic [SEL_W-1:0]  ptr_hi_idx;
  logic [SEL_W-1:0]  addr_lo_idx;
  logic [SEL_W-1:0]  addr_hi_idx;
  logic [ADDR_W-1:0] ptr_cur;
  logic [ADDR_W-1:0] ptr_next;
  logic              ptr_wrap;
  logic              ptr_active;
  logic              ptr_conflict;
  logic              ptr_do;
  logic              wrap_q;
  logic              conflict_q;
  logic [DATA_W-1:0] alu_l;
  logic [DATA_W-1:0] alu_r;
  logic [DATA_W-1:0] addr_lo;
  logic [DATA_W-1:0] addr_hi;

  assign ptr_lo_idx  = {bus.i_ptr_sel, 1'b0};
  assign ptr_hi_idx  = {bus.i_ptr_sel, 1'b1};
  assign addr_lo_idx = {bus.i_addr_sel, 1'b0};
  assign addr_hi_idx = {bus.i_addr_sel, 1'b1};
  assign ptr_cur     = {regs[ptr_hi_idx], regs[ptr_lo_idx]};

  // Single shared step unit, fed by the pair chosen with i_ptr_sel
  dcpu_ptr_incdec #(
    .ADDR_W (ADDR_W)
  ) u_incdec (
    .i_val  (ptr_cur),
    .i_dec  (bus.i_ptr_op == PTR_DEC),
    .o_res  (ptr_next),
    .o_wrap (ptr_wrap)
  );

  // A load into either byte of the targeted pair beats the pointer op
  always_comb begin
    ptr_active   = (bus.i_ptr_op == PTR_INC) || (bus.i_ptr_op == PTR_DEC);
    ptr_conflict = ptr_active && bus.i_load &&
                   (bus.i_load_reg_sel[SEL_W-1:1] == bus.i_ptr_sel);
    ptr_do       = ptr_active && !ptr_conflict;
  end

  // Register array: pointer step and load in parallel, never the same pair
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (ptr_do) begin
        regs[ptr_lo_idx] <= ptr_next[DATA_W-1:0];
        regs[ptr_hi_idx] <= ptr_next[ADDR_W-1:DATA_W];
      end
      if (bus.i_load) begin
        regs[bus.i_load_reg_sel] <= bus.i_dat;
      end
    end
  end

  // One-cycle status pulses describing the previous cycle's pointer op
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wrap_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      wrap_q     <= ptr_do && ptr_wrap;
      conflict_q <= ptr_conflict;
    end
  end

  // Read muxes; with forwarding a same-cycle load shows through per byte
  always_comb begin
    alu_l   = regs[bus.i_alu_l_sel];
    alu_r   = regs[bus.i_alu_r_sel];
    addr_lo = regs[addr_lo_idx];
    addr_hi = regs[addr_hi_idx];
`ifdef DCPU_RF_BYPASS_EN
    if (bus.i_load) begin
      if (bus.i_load_reg_sel == bus.i_alu_l_sel) alu_l   = bus.i_dat;
      if (bus.i_load_reg_sel == bus.i_alu_r_sel) alu_r   = bus.i_dat;
      if (bus.i_load_reg_sel == addr_lo_idx)     addr_lo = bus.i_dat;
      if (bus.i_load_reg_sel == addr_hi_idx)     addr_hi = bus.i_dat;
    end
`else
    // stored values only
`endif
  end

  assign bus.o_alu_l        = alu_l;
  assign bus.o_alu_r        = alu_r;
  assign bus.o_addr         = {addr_hi, addr_lo};
  assign bus.o_ptr_wrap     = wrap_q;
  assign bus.o_ptr_conflict = conflict_q;

endmodule

// File: tb/tb_dcpu_regfile_ptr.sv
// Directed bench for dcpu_regfile_ptr: default geometry plus a 16-bit/8-register instance.
// Latency: expects 0-cycle reads and 1-cycle load/pointer/flag updates.
// Backpressure: none exercised; all inputs are accepted every cycle.
module tb_dcpu_regfile_ptr;
  import dcpu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  dcpu_regfile_ptr_if #(.DATA_W(8),  .NREGS(16)) ifa ();
  dcpu_regfile_ptr_if #(.DATA_W(16), .NREGS(8))  ifb ();

  dcpu_regfile_ptr #(.DATA_W(8), .NREGS(16)) u_dut_a (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (ifa.slave)
  );

  dcpu_regfile_ptr #(.DATA_W(16), .NREGS(8)) u_dut_b (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ifa.i_dat = '0; ifa.i_load = 1'b0; ifa.i_load_reg_sel = '0;
    ifa.i_alu_l_sel = '0; ifa.i_alu_r_sel = '0; ifa.i_addr_sel = '0;
    ifa.i_ptr_op = PTR_NOP; ifa.i_ptr_sel = '0;
  endtask

  task automatic idle_b();
    ifb.i_dat = '0; ifb.i_load = 1'b0; ifb.i_load_reg_sel = '0;
    ifb.i_alu_l_sel = '0; ifb.i_alu_r_sel = '0; ifb.i_addr_sel = '0;
    ifb.i_ptr_op = PTR_NOP; ifb.i_ptr_sel = '0;
  endtask

  task automatic load_a(input logic [3:0] sel, input logic [7:0] dat);
    ifa.i_load = 1'b1; ifa.i_load_reg_sel = sel; ifa.i_dat = dat;
    cyc();
    ifa.i_load = 1'b0;
  endtask

  task automatic load_b(input logic [2:0] sel, input logic [15:0] dat);
    ifb.i_load = 1'b1; ifb.i_load_reg_sel = sel; ifb.i_dat = dat;
    cyc();
    ifb.i_load = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle_a();
    idle_b();
    #12;
    rst_n = 1'b1;
    #1;

    // reset state
    check("rst_alu_l", ifa.o_alu_l, 8'h00);
    check("rst_addr", ifa.o_addr, 16'h0000);
    check("rst_wrap", ifa.o_ptr_wrap, 1'b0);
    check("rst_conflict", ifa.o_ptr_conflict, 1'b0);

    // carry from low byte into high byte
    load_a(4'd2, 8'hFF);
    load_a(4'd3, 8'h00);
    ifa.i_addr_sel = 3'd1; ifa.i_ptr_sel = 3'd1; ifa.i_ptr_op = PTR_INC;
    #1;
    check("inc_issue_addr", ifa.o_addr, 16'h00FF);
    cyc();
    ifa.i_ptr_op = PTR_NOP;
    #1;
    check("inc_carry_addr", ifa.o_addr, 16'h0100);
    check("inc_carry_wrap", ifa.o_ptr_wrap, 1'b0);

    // decrement from zero wraps, single-cycle pulse
    load_a(4'd2, 8'h00);
    load_a(4'd3, 8'h00);
    ifa.i_ptr_op = PTR_DEC;
    cyc();
    ifa.i_ptr_op = PTR_NOP;
    check("dec_wrap_addr", ifa.o_addr, 16'hFFFF);
    check("dec_wrap_pulse", ifa.o_ptr_wrap, 1'b1);
    cyc();
    check("dec_wrap_end", ifa.o_ptr_wrap, 1'b0);

    // increment from all-ones wraps
    ifa.i_ptr_op = PTR_INC;
    cyc();
    ifa.i_ptr_op = PTR_NOP;
    check("inc_wrap_addr", ifa.o_addr, 16'h0000);
    check("inc_wrap_pulse", ifa.o_ptr_wrap, 1'b1);
    cyc();
    check("inc_wrap_end", ifa.o_ptr_wrap, 1'b0);

    // load into targeted pair wins over the pointer op
    load_a(4'd0, 8'h34);
    load_a(4'd1, 8'h12);
    ifa.i_addr_sel = 3'd0; ifa.i_ptr_sel = 3'd0; ifa.i_ptr_op = PTR_INC;
    ifa.i_load = 1'b1; ifa.i_load_reg_sel = 4'd1; ifa.i_dat = 8'hAB;
    cyc();
    ifa.i_ptr_op = PTR_NOP; ifa.i_load = 1'b0;
    check("cfl_addr", ifa.o_addr, 16'hAB34);
    check("cfl_pulse", ifa.o_ptr_conflict, 1'b1);
    cyc();
    check("cfl_end", ifa.o_ptr_conflict, 1'b0);

    // load elsewhere runs in parallel with the pointer op
    load_a(4'd1, 8'h12);
    ifa.i_ptr_op = PTR_INC;
    ifa.i_load = 1'b1; ifa.i_load_reg_sel = 4'd5; ifa.i_dat = 8'h77;
    cyc();
    ifa.i_ptr_op = PTR_NOP; ifa.i_load = 1'b0; ifa.i_alu_l_sel = 4'd5;
    #1;
    check("par_addr", ifa.o_addr, 16'h1235);
    check("par_reg5", ifa.o_alu_l, 8'h77);
    check("par_conflict", ifa.o_ptr_conflict, 1'b0);

    // conflict on an all-ones pair suppresses the wrap flag
    load_a(4'd0, 8'hFF);
    load_a(4'd1, 8'hFF);
    ifa.i_ptr_op = PTR_INC;
    ifa.i_load = 1'b1; ifa.i_load_reg_sel = 4'd0; ifa.i_dat = 8'h11;
    cyc();
    ifa.i_ptr_op = PTR_NOP; ifa.i_load = 1'b0;
    check("cflw_addr", ifa.o_addr, 16'hFF11);
    check("cflw_conflict", ifa.o_ptr_conflict, 1'b1);
    check("cflw_wrap", ifa.o_ptr_wrap, 1'b0);

    // reserved op leaves everything alone
    ifa.i_ptr_op = PTR_RSV;
    cyc();
    ifa.i_ptr_op = PTR_NOP;
    check("rsv_addr", ifa.o_addr, 16'hFF11);
    check("rsv_wrap", ifa.o_ptr_wrap, 1'b0);
    check("rsv_conflict", ifa.o_ptr_conflict, 1'b0);

    // same-cycle read of a register being loaded, both ports on reg4
    ifa.i_alu_l_sel = 4'd4; ifa.i_alu_r_sel = 4'd4; ifa.i_addr_sel = 3'd2;
    ifa.i_load = 1'b1; ifa.i_load_reg_sel = 4'd4; ifa.i_dat = 8'h5A;
    #1;
`ifdef DCPU_RF_BYPASS_EN
    check("byp_alu_l", ifa.o_alu_l, 8'h5A);
    check("byp_alu_r", ifa.o_alu_r, 8'h5A);
    check("byp_addr", ifa.o_addr, 16'h775A);
`else
    check("byp_alu_l", ifa.o_alu_l, 8'h00);
    check("byp_alu_r", ifa.o_alu_r, 8'h00);
    check("byp_addr", ifa.o_addr, 16'h7700);
`endif
    cyc();
    ifa.i_load = 1'b0;
    #1;
    check("wr_alu_l", ifa.o_alu_l, 8'h5A);
    check("wr_alu_r", ifa.o_alu_r, 8'h5A);
    check("wr_addr", ifa.o_addr, 16'h775A);

    // wide geometry: 16-bit data, 8 registers, 32-bit pointers
    load_b(3'd0, 16'hFFFF);
    load_b(3'd1, 16'h0000);
    ifb.i_addr_sel = 2'd0; ifb.i_ptr_sel = 2'd0; ifb.i_ptr_op = PTR_INC;
    cyc();
    ifb.i_ptr_op = PTR_NOP;
    check("w_inc_addr", ifb.o_addr, 32'h0001_0000);
    check("w_inc_wrap", ifb.o_ptr_wrap, 1'b0);
    ifb.i_addr_sel = 2'd3; ifb.i_ptr_sel = 2'd3; ifb.i_ptr_op = PTR_DEC;
    cyc();
    ifb.i_ptr_op = PTR_NOP;
    check("w_dec_addr", ifb.o_addr, 32'hFFFF_FFFF);
    check("w_dec_wrap", ifb.o_ptr_wrap, 1'b1);
    cyc();
    check("w_dec_wrap_end", ifb.o_ptr_wrap, 1'b0);

    // asynchronous reset mid-stream with a flag high and a load pending
    ifa.i_addr_sel = 3'd0; ifa.i_ptr_sel = 3'd0; ifa.i_ptr_op = PTR_INC;
    ifa.i_load = 1'b1; ifa.i_load_reg_sel = 4'd1; ifa.i_dat = 8'h42;
    cyc();
    ifa.i_ptr_op = PTR_NOP;
    check("pre_rst_conflict", ifa.o_ptr_conflict, 1'b1);
    ifa.i_load_reg_sel = 4'd6; ifa.i_dat = 8'h99;
    ifa.i_alu_l_sel = 4'd6; ifa.i_alu_r_sel = 4'd5;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_conflict", ifa.o_ptr_conflict, 1'b0);
    check("arst_wrap", ifa.o_ptr_wrap, 1'b0);
    check("arst_addr", ifa.o_addr, 16'h0000);
    check("arst_reg5", ifa.o_alu_r, 8'h00);
    check("arst_b_addr", ifb.o_addr, 32'h0000_0000);
    cyc();
    ifa.i_load = 1'b0;
    rst_n = 1'b1;
    #1;
    check("arst_drop_load", ifa.o_alu_l, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
